// File: rtl/sequence_generator.sv
// Serial pattern transmitter: shifts a captured WIDTH-bit pattern out
// MSB-first for reps frames, with GAP idle cycles between frames.
module sequence_generator #(
  parameter int               WIDTH       = 6,
  parameter logic [WIDTH-1:0] DEFAULT_PAT = 6'b101101,
  parameter int               GAP         = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pat_in,
  input  logic [3:0]       reps,
  output logic             op,
  output logic             op_valid,
  output logic             frame_end,
  output logic             busy,
  output logic             done
);

  localparam int             IW     = $clog2(WIDTH);
  localparam logic [IW-1:0]  LAST   = IW'(WIDTH - 1);
  localparam logic [3:0]     GAP_M1 = 4'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pat_q   <= DEFAULT_PAT;
      idx_q   <= LAST;
      cnt_q   <= 4'd0;
      gap_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort && reps != 4'd0) begin
          pat_d   = pat_in;
          cnt_d   = reps;
          idx_d   = LAST;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (idx_q != '0) begin
          idx_d = idx_q - 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = S_DONE;
          end else if (GAP > 0) begin
            gap_d   = GAP_M1;
            state_d = S_GAP;
          end else begin
            idx_d = LAST;
          end
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) begin
          idx_d   = LAST;
          state_d = S_SEND;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // abort drops the run without a done pulse; pattern is retained
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_comb begin
    op        = 1'b0;
    op_valid  = 1'b0;
    frame_end = 1'b0;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    if (state_q == S_SEND) begin
      op        = pat_q[idx_q];
      op_valid  = 1'b1;
      frame_end = (idx_q == '0);
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator: GAP=2 and GAP=0 instances,
// per-cycle output traces compared against hand-computed vectors.
module tb_sequence_generator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       start0 = 1'b0;
  logic       abort = 1'b0;
  logic [5:0] pat_in = 6'd0;
  logic [3:0] reps = 4'd0;

  logic op, op_valid, frame_end, busy, done;
  logic op0, op_valid0, frame_end0, busy0, done0;

  int checks = 0;
  int errors = 0;

  logic [31:0] t_op, t_v, t_fe, t_dn, t_bz;

  always #5 clk = ~clk;

  sequence_generator #(.WIDTH(6), .DEFAULT_PAT(6'b101101), .GAP(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pat_in(pat_in), .reps(reps),
    .op(op), .op_valid(op_valid), .frame_end(frame_end),
    .busy(busy), .done(done)
  );

  sequence_generator #(.WIDTH(6), .DEFAULT_PAT(6'b101101), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort),
    .pat_in(pat_in), .reps(reps),
    .op(op0), .op_valid(op_valid0), .frame_end(frame_end0),
    .busy(busy0), .done(done0)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; launches start, then records n cycles of outputs,
  // first cycle in the MSB. inj>=0 pulses start/new pat or abort for a cycle.
  task automatic run(input bit sel, input logic [5:0] p, input logic [3:0] r,
                     input int n, input int inj, input bit inj_abort,
                     output logic [31:0] o_op, output logic [31:0] o_v,
                     output logic [31:0] o_fe, output logic [31:0] o_dn,
                     output logic [31:0] o_bz);
    o_op = '0; o_v = '0; o_fe = '0; o_dn = '0; o_bz = '0;
    pat_in = p;
    reps   = r;
    if (sel) start0 = 1'b1;
    else     start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start0 = 1'b0;
    for (int i = 0; i < n; i++) begin
      o_op[n-1-i] = sel ? op0        : op;
      o_v[n-1-i]  = sel ? op_valid0  : op_valid;
      o_fe[n-1-i] = sel ? frame_end0 : frame_end;
      o_dn[n-1-i] = sel ? done0      : done;
      o_bz[n-1-i] = sel ? busy0      : busy;
      if (i == inj) begin
        if (inj_abort) abort = 1'b1;
        else begin
          start  = 1'b1;
          pat_in = 6'b111111;
          reps   = 4'd3;
        end
      end
      if (i == inj + 1) begin
        abort = 1'b0;
        start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #12;
    chk("rst_op", {31'd0, op}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run(1'b0, 6'b101101, 4'd1, 8, -5, 1'b0, t_op, t_v, t_fe, t_dn, t_bz);
    chk("r1_op", t_op, 32'b10110100);
    chk("r1_v", t_v, 32'b11111100);
    chk("r1_fe", t_fe, 32'b00000100);
    chk("r1_done", t_dn, 32'b00000010);
    chk("r1_busy", t_bz, 32'b11111110);

    run(1'b0, 6'b101101, 4'd3, 24, -5, 1'b0, t_op, t_v, t_fe, t_dn, t_bz);
    chk("r3_op", t_op, 32'b101101001011010010110100);
    chk("r3_v", t_v, 32'b111111001111110011111100);
    chk("r3_fe", t_fe, 32'b000001000000010000000100);
    chk("r3_done", t_dn, 32'b000000000000000000000010);
    chk("r3_busy", t_bz, 32'hFFFFFE);

    run(1'b1, 6'b100001, 4'd2, 14, -5, 1'b0, t_op, t_v, t_fe, t_dn, t_bz);
    chk("g0_op", t_op, 32'b10000110000100);
    chk("g0_v", t_v, 32'b11111111111100);
    chk("g0_fe", t_fe, 32'b00000100000100);
    chk("g0_done", t_dn, 32'b00000000000010);
    chk("g0_busy", t_bz, 32'b11111111111110);

    run(1'b0, 6'b101101, 4'd0, 4, -5, 1'b0, t_op, t_v, t_fe, t_dn, t_bz);
    chk("r0_v", t_v, 32'd0);
    chk("r0_done", t_dn, 32'd0);
    chk("r0_busy", t_bz, 32'd0);

    run(1'b0, 6'b101101, 4'd1, 8, 2, 1'b0, t_op, t_v, t_fe, t_dn, t_bz);
    chk("mid_op", t_op, 32'b10110100);
    chk("mid_done", t_dn, 32'b00000010);
    chk("mid_busy", t_bz, 32'b11111110);

    run(1'b0, 6'b101101, 4'd3, 14, 11, 1'b1, t_op, t_v, t_fe, t_dn, t_bz);
    chk("ab_op", t_op, 32'b10110100101100);
    chk("ab_v", t_v, 32'b11111100111100);
    chk("ab_fe", t_fe, 32'b00000100000000);
    chk("ab_done", t_dn, 32'd0);
    chk("ab_busy", t_bz, 32'b11111111111100);

    abort = 1'b1;
    run(1'b0, 6'b101101, 4'd1, 3, -5, 1'b0, t_op, t_v, t_fe, t_dn, t_bz);
    abort = 1'b0;
    chk("abst_busy", t_bz, 32'd0);
    chk("abst_v", t_v, 32'd0);

    pat_in = 6'b111111;
    reps   = 4'd1;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_op", {31'd0, op}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_op", {31'd0, op}, 32'd0);
    chk("arst_v", {31'd0, op_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_pat", {26'd0, dut.pat_q}, 32'b101101);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
